// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Four-channel button front end. Each channel is synchronised,
//               debounced and classified as a short or long press; the
//               resulting events are queued one-deep per channel and handed
//               to a single consumer through a round-robin valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'h000F,
  parameter logic [23:0] LONG_CYCLES     = 24'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttonRaw,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [1:0] event_id,
  output logic       event_long,
  output logic [3:0] overrun
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_DONE = 2'd2
  } press_state_t;

  localparam int c_NUM_CH = 4;

  // Per-channel press reports, one-cycle pulses from each channel FSM.
  logic [3:0] w_post;
  logic [3:0] w_post_long;

  // Event queue (one slot per channel) and arbiter state.
  logic [3:0] r_pending;
  logic [3:0] r_type;
  logic [3:0] r_overrun;
  logic [3:0] w_accept;
  logic       r_event_valid;
  logic [1:0] r_event_id;
  logic       r_event_long;
  logic [1:0] r_last;
  logic       w_found;
  logic [1:0] w_sel;

  genvar gi;
  generate
    for (gi = 0; gi < c_NUM_CH; gi++) begin : g_chan
      logic         r_sync0;
      logic         r_sync1;
      logic [15:0]  r_stab_cnt;
      logic         r_deb;
      logic [23:0]  r_hold_cnt;
      press_state_t r_state;
      logic         r_post;
      logic         r_post_long;
      logic         w_load;
      logic         w_rise;
      logic         w_fall;

      // The debounced level follows the synchronised input once it has been
      // stable long enough; rise/fall mark the edge on which it changes.
      assign w_load = (r_stab_cnt == DEBOUNCE_CYCLES);
      assign w_rise = w_load &  r_sync1 & ~r_deb;
      assign w_fall = w_load & ~r_sync1 &  r_deb;

      // Two-flop synchroniser plus stability counter and debounced level.
      // The counter parks at the threshold so a long stable level never
      // wraps around.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync0    <= 1'b0;
          r_sync1    <= 1'b0;
          r_stab_cnt <= 16'd0;
          r_deb      <= 1'b0;
        end else begin
          r_sync0 <= buttonRaw[gi];
          r_sync1 <= r_sync0;
          if (r_sync0 != r_sync1) begin
            r_stab_cnt <= 16'd0;
          end else if (r_stab_cnt != DEBOUNCE_CYCLES) begin
            r_stab_cnt <= r_stab_cnt + 16'd1;
          end
          if (w_load) begin
            r_deb <= r_sync1;
          end
        end
      end

      // Press classifier: measures how long the debounced level stays high
      // and reports exactly one short or long event per press.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state     <= ST_IDLE;
          r_hold_cnt  <= 24'd0;
          r_post      <= 1'b0;
          r_post_long <= 1'b0;
        end else begin
          r_post      <= 1'b0;
          r_post_long <= 1'b0;
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                r_hold_cnt <= 24'd0;
                r_state    <= ST_HELD;
              end
            end
            ST_HELD: begin
              if (r_hold_cnt == LONG_CYCLES) begin
                r_post      <= 1'b1;
                r_post_long <= 1'b1;
                // A release coinciding with the long threshold needs no
                // further wait for a falling edge.
                r_state     <= w_fall ? ST_IDLE : ST_LONG_DONE;
              end else if (w_fall) begin
                r_post      <= 1'b1;
                r_post_long <= 1'b0;
                r_state     <= ST_IDLE;
              end else begin
                r_hold_cnt <= r_hold_cnt + 24'd1;
              end
            end
            ST_LONG_DONE: begin
              if (w_fall) begin
                r_state <= ST_IDLE;
              end
            end
            default: begin
              r_state <= ST_IDLE;
            end
          endcase
        end
      end

      assign w_post[gi]      = r_post;
      assign w_post_long[gi] = r_post_long;
    end
  endgenerate

  // Decode which channel's slot the consumer is emptying this cycle.
  always_comb begin
    w_accept = 4'b0000;
    if (r_event_valid && event_ready) begin
      w_accept[r_event_id] = 1'b1;
    end
  end

  // One-deep event slot per channel; a new report landing on a full slot
  // that is not being drained is dropped and flagged as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 4'b0000;
      r_type    <= 4'b0000;
      r_overrun <= 4'b0000;
    end else begin
      for (int i = 0; i < c_NUM_CH; i++) begin
        if (w_post[i]) begin
          if (r_pending[i] && !w_accept[i]) begin
            r_overrun[i] <= 1'b1;
          end else begin
            r_pending[i] <= 1'b1;
            r_type[i]    <= w_post_long[i];
          end
        end else if (w_accept[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    logic [1:0] w_idx;
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 1; k <= c_NUM_CH; k++) begin
      w_idx = r_last + k[1:0];
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Output register: holds the presented event until accepted, then leaves
  // one idle cycle before the next grant so the slot clear is visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_event_valid <= 1'b0;
      r_event_id    <= 2'd0;
      r_event_long  <= 1'b0;
      r_last        <= 2'd3;
    end else if (r_event_valid) begin
      if (event_ready) begin
        r_event_valid <= 1'b0;
      end
    end else if (w_found) begin
      r_event_valid <= 1'b1;
      r_event_id    <= w_sel;
      r_event_long  <= r_type[w_sel];
      r_last        <= w_sel;
    end
  end

  assign event_valid = r_event_valid;
  assign event_id    = r_event_id;
  assign event_long  = r_event_long;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_arbiter
// Description : Scoreboard bench for button_event_arbiter. Stimulus pushes the
//               expected {long,id} of each press; a monitor pops on every
//               accepted handshake and also checks the bubble and hold rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttonRaw;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_id;
  logic       event_long;
  logic [3:0] overrun;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int last_evt_cycle = 0;

  logic [2:0] sb[$];

  button_event_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .buttonRaw   (buttonRaw),
    .event_ready (event_ready),
    .event_valid (event_valid),
    .event_id    (event_id),
    .event_long  (event_long),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; monitor samples on falling.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    buttonRaw = 4'b0000;
    event_ready = 1'b1;
    sb.delete();
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int budget, input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      tick(1);
      t++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s timeout actual=%0d_left required=0_left", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compares accepted events against the scoreboard in order.
  initial begin
    logic       prev_hs;
    logic       prev_stall;
    logic [2:0] prev_out;
    logic [2:0] exp;
    prev_hs    = 1'b0;
    prev_stall = 1'b0;
    prev_out   = 3'b000;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hs    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_hs) check("bubble_after_accept", {31'd0, event_valid}, 32'd0);
        if (prev_stall && event_valid)
          check("hold_stable", {29'd0, event_long, event_id}, {29'd0, prev_out});
        if (event_valid && event_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=id%0d_long%0d required=none", event_id, event_long);
          end else begin
            exp = sb.pop_front();
            check("event_id", {30'd0, event_id}, {30'd0, exp[1:0]});
            check("event_long", {31'd0, event_long}, {31'd0, exp[2]});
            last_evt_cycle = cycle;
          end
        end
        prev_hs    = event_valid & event_ready;
        prev_stall = event_valid & ~event_ready;
        prev_out   = {event_long, event_id};
      end
    end
  end

  initial begin
    int t0;
    reset       = 1'b1;
    buttonRaw   = 4'b0000;
    event_ready = 1'b1;
    tick(3);
    check("reset_valid",   {31'd0, event_valid}, 32'd0);
    check("reset_id",      {30'd0, event_id},    32'd0);
    check("reset_long",    {31'd0, event_long},  32'd0);
    check("reset_overrun", {28'd0, overrun},     32'd0);
    reset = 1'b0;
    tick(1);

    // Short press on channel 1.
    sb.push_back({1'b0, 2'd1});
    buttonRaw[1] = 1'b1;
    tick(200);
    buttonRaw[1] = 1'b0;
    drain(100, "short_ch1");
    tick(100);

    // Long press on channel 2; nothing more on release.
    do_reset();
    sb.push_back({1'b1, 2'd2});
    t0 = cycle;
    buttonRaw[2] = 1'b1;
    tick(1500);
    buttonRaw[2] = 1'b0;
    tick(100);
    drain(10, "long_ch2");
    total++;
    if (last_evt_cycle - t0 < 1010 || last_evt_cycle - t0 > 1030) begin
      bad++;
      $display("FAIL long_latency actual=%0d required=1010..1030", last_evt_cycle - t0);
    end

    // Glitch shorter than the debounce window.
    do_reset();
    buttonRaw[0] = 1'b1;
    tick(10);
    buttonRaw[0] = 1'b0;
    tick(100);
    check("glitch_no_valid", {31'd0, event_valid}, 32'd0);

    // Simultaneous releases on 0,1,3: round-robin from channel 0.
    do_reset();
    sb.push_back({1'b0, 2'd0});
    sb.push_back({1'b0, 2'd1});
    sb.push_back({1'b0, 2'd3});
    buttonRaw = 4'b1011;
    tick(100);
    buttonRaw = 4'b0000;
    drain(100, "rr_order");
    tick(20);

    // Two presses on channel 3 while stalled: one kept, overrun flagged.
    do_reset();
    event_ready = 1'b0;
    buttonRaw[3] = 1'b1;
    tick(100);
    buttonRaw[3] = 1'b0;
    tick(100);
    buttonRaw[3] = 1'b1;
    tick(100);
    buttonRaw[3] = 1'b0;
    tick(100);
    check("overrun_ch3", {28'd0, overrun}, 32'h8);
    check("stalled_valid", {31'd0, event_valid}, 32'd1);
    sb.push_back({1'b0, 2'd3});
    event_ready = 1'b1;
    drain(20, "overrun_drain");
    tick(100);

    // Reset while an event is presented and channel 0 is held.
    do_reset();
    event_ready = 1'b0;
    buttonRaw[1] = 1'b1;
    tick(100);
    buttonRaw[1] = 1'b0;
    tick(50);
    buttonRaw[0] = 1'b1;
    tick(60);
    check("pre_reset_valid", {31'd0, event_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_valid",   {31'd0, event_valid}, 32'd0);
    check("midreset_id",      {30'd0, event_id},    32'd0);
    check("midreset_long",    {31'd0, event_long},  32'd0);
    check("midreset_overrun", {28'd0, overrun},     32'd0);
    sb.delete();
    buttonRaw = 4'b0000;
    tick(3);
    reset = 1'b0;
    event_ready = 1'b1;
    tick(200);
    check("post_reset_idle", {31'd0, event_valid}, 32'd0);

    // Button held across reset counts as a fresh press afterwards.
    do_reset();
    buttonRaw[2] = 1'b1;
    tick(50);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    sb.push_back({1'b0, 2'd2});
    tick(100);
    buttonRaw[2] = 1'b0;
    drain(100, "held_through_reset");
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
